// File: rtl/serial_match_pkg.sv
// Shared types and constants for the serial "1101" match controller.
package serial_match_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} ctrl_state_t;

  typedef enum logic [2:0] {S0, S1, S11, S110, S1101} det_state_t;

  localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/moore_1101_det.sv
// Overlapping Moore detector for the bit pattern 1101; advances only when en is high.
module moore_1101_det
  import serial_match_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  input  logic i,
  output logic o
);

  det_state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= S0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S0;
    end else if (en) begin
      case (state_q)
        S0:      state_d = i ? S1    : S0;
        S1:      state_d = i ? S11   : S0;
        S11:     state_d = i ? S11   : S110;
        S110:    state_d = i ? S1101 : S0;
        S1101:   state_d = i ? S11   : S0;
        default: state_d = S0;
      endcase
    end
  end

  assign o = (state_q == S1101);

endmodule

// File: rtl/serial_match_ctrl.sv
// Accepts words over valid/ready, shifts them MSB-first into the 1101 detector,
// and reports a saturating per-word match count with a one-cycle result strobe.
module serial_match_ctrl
  import serial_match_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  clear,
  output logic                  serial_bit,
  output logic                  detect_pulse,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic                  result_valid
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  ctrl_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  en_dly_q, en_dly_d;
  logic                  det_en, det_clr, det_o;

  moore_1101_det u_det (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (det_clr),
    .en    (det_en),
    .i     (serial_bit),
    .o     (det_o)
  );

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    cnt_d        = cnt_q;
    det_en       = 1'b0;
    det_clr      = 1'b0;
    data_ready   = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    serial_bit   = 1'b0;

    // Detector output is Moore, so a match on bit k shows one cycle later; en_dly gates it.
    detect_pulse = det_o & en_dly_q;
    if (detect_pulse && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);

    case (state_q)
      IDLE: begin
        busy       = 1'b0;
        data_ready = ~clear;
        if (clear) begin
          det_clr = 1'b1;
        end else if (data_valid) begin
          sr_d      = data_in;
          bit_cnt_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        serial_bit = sr_q[DATA_WIDTH-1];
        det_en     = 1'b1;
        sr_d       = sr_q << 1;
        bit_cnt_d  = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BW'(DATA_WIDTH - 1)) state_d = FLUSH;
      end
      FLUSH: state_d = DONE;
      DONE: begin
        result_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    en_dly_d = det_en;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      en_dly_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      en_dly_q  <= en_dly_d;
    end
  end

  assign match_count = cnt_q;

endmodule
